// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and types for simple_cpu and its fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int                     INSTR_WIDTH = 20;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR   = 20'h00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_store.sv
`default_nettype none
// ============================================================================
// Module      : instr_store
// Description : Program store, synchronous write / asynchronous read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_store #(
    parameter int WIDTH     = 20,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] r_mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Loadable program store plus PC sequencer feeding simple_cpu.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int                     INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter int                     PC_BITS     = 5,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = cpu_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    input  logic [INSTR_WIDTH-1:0] load_data,
    output logic                   load_ready,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   jump_valid,
    input  logic [PC_BITS-1:0]     jump_addr,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_BITS-1:0]     pc,
    output logic                   running,
    output logic                   done
);

    import cpu_pkg::*;

    localparam logic [PC_BITS:0] c_depth = (PC_BITS+1)'(2**PC_BITS);
    localparam logic [PC_BITS:0] c_one   = (PC_BITS+1)'(1);

    fetch_state_t           r_state;
    logic [PC_BITS:0]       r_wr_ptr;
    logic [PC_BITS:0]       r_prog_len;
    logic [PC_BITS-1:0]     r_pc;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_running;
    logic                   r_done;

    logic                   w_wr_en;
    logic [PC_BITS:0]       w_pc_inc;
    logic                   w_jump_ok;
    logic [PC_BITS-1:0]     w_rd_addr;
    logic [INSTR_WIDTH-1:0] w_rd_data;

    assign load_ready = (r_state == IDLE) && (r_wr_ptr < c_depth) && !clear && !start;
    assign w_wr_en    = load_valid && load_ready;

    // Extra bit keeps a full 32-word program from wrapping back to address 0.
    assign w_pc_inc  = {1'b0, r_pc} + c_one;
    assign w_jump_ok = ({1'b0, jump_addr} < r_prog_len);

    always_comb begin
        w_rd_addr = '0;
        if (r_state == RUN) begin
            w_rd_addr = jump_valid ? jump_addr : w_pc_inc[PC_BITS-1:0];
        end
    end

    instr_store #(
        .WIDTH     (INSTR_WIDTH),
        .ADDR_BITS (PC_BITS)
    ) u_store (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr[PC_BITS-1:0]),
        .wr_data (load_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_prog_len <= '0;
            r_pc       <= '0;
            r_instr    <= NOP_INSTR;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clear) begin
                        r_wr_ptr   <= '0;
                        r_prog_len <= '0;
                    end else if (start) begin
                        if (r_prog_len != '0) begin
                            r_state   <= RUN;
                            r_pc      <= '0;
                            r_instr   <= w_rd_data;
                            r_running <= 1'b1;
                        end
                    end else if (w_wr_en) begin
                        r_wr_ptr   <= r_wr_ptr + c_one;
                        r_prog_len <= r_wr_ptr + c_one;
                    end
                end
                RUN: begin
                    // A jump overrides stall so a redirect is never lost.
                    if (jump_valid) begin
                        if (w_jump_ok) begin
                            r_pc    <= jump_addr;
                            r_instr <= w_rd_data;
                        end else begin
                            r_state <= DONE;
                            r_instr <= NOP_INSTR;
                            r_done  <= 1'b1;
                        end
                    end else if (!stall) begin
                        if (w_pc_inc == r_prog_len) begin
                            r_state <= DONE;
                            r_instr <= NOP_INSTR;
                            r_done  <= 1'b1;
                        end else begin
                            r_pc    <= w_pc_inc[PC_BITS-1:0];
                            r_instr <= w_rd_data;
                        end
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_done    <= 1'b0;
                    r_running <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign instruction = r_instr;
    assign pc          = r_pc;
    assign running     = r_running;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch against a program model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [19:0] c_nop = 20'h00000;
    localparam int c_m_idle = 0;
    localparam int c_m_run  = 1;
    localparam int c_m_done = 2;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [19:0] load_data;
    logic        load_ready;
    logic        clear;
    logic        start;
    logic        stall;
    logic        jump_valid;
    logic [4:0]  jump_addr;
    logic [19:0] instruction;
    logic [4:0]  pc;
    logic        running;
    logic        done;

    int n_checks;
    int n_errors;
    int done_seen;
    int run_cycles;

    // Program model: loaded words, program length, current index, phase.
    logic [19:0] m_mem [32];
    int          m_wptr;
    int          m_len;
    int          m_pc;
    int          m_state;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .clear       (clear),
        .start       (start),
        .stall       (stall),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .instruction (instruction),
        .pc          (pc),
        .running     (running),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("instruction", instruction, (m_state == c_m_run) ? m_mem[m_pc] : c_nop);
        chk("pc", pc, m_pc);
        chk("running", running, m_state != c_m_idle);
        chk("done", done, m_state == c_m_done);
    endtask

    task automatic model_reset();
        m_wptr = 0; m_len = 0; m_pc = 0; m_state = c_m_idle;
    endtask

    task automatic cycle(input bit lv, input logic [19:0] ld, input bit clr, input bit st,
                         input bit stl, input bit jv, input logic [4:0] ja);
        bit exp_lr;
        load_valid = lv; load_data = ld; clear = clr; start = st;
        stall = stl; jump_valid = jv; jump_addr = ja;
        exp_lr = (m_state == c_m_idle) && (m_wptr < 32) && !clr && !st;
        #2;
        chk("load_ready", load_ready, exp_lr);
        @(posedge clk);
        case (m_state)
            c_m_idle: begin
                if (clr) begin
                    m_wptr = 0; m_len = 0;
                end else if (st) begin
                    if (m_len > 0) begin m_state = c_m_run; m_pc = 0; end
                end else if (lv && exp_lr) begin
                    m_mem[m_wptr] = ld; m_wptr++; m_len = m_wptr;
                end
            end
            c_m_run: begin
                if (jv) begin
                    if (int'(ja) < m_len) m_pc = int'(ja);
                    else m_state = c_m_done;
                end else if (!stl) begin
                    if (m_pc + 1 == m_len) m_state = c_m_done;
                    else m_pc++;
                end
            end
            default: m_state = c_m_idle;
        endcase
        #1;
        check_outputs();
        if (done) done_seen++;
        if (running && !done) run_cycles++;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic load_prog(input int n, input int seed);
        cycle(1'b0, 20'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 20'(seed + i * 20'h01357), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        end
    endtask

    task automatic run_to_idle(input int budget);
        int k;
        k = 0;
        while (m_state != c_m_idle && k < budget) begin
            idle_cycle();
            k++;
        end
        chk("run_budget", k < budget, 1);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b0; load_valid = 1'b0; load_data = '0; clear = 1'b0; start = 1'b0;
        stall = 1'b0; jump_valid = 1'b0; jump_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_load_ready", load_ready, 1);
        rst = 1'b1;

        // Three-word program: explicit issue sequence and a single done pulse.
        cycle(1'b1, 20'h11111, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle(1'b1, 20'h22222, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle(1'b1, 20'h33333, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        done_seen = 0;
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        chk("t1_i0", instruction, 20'h11111); chk("t1_pc0", pc, 0); chk("t1_run", running, 1);
        idle_cycle();
        chk("t1_i1", instruction, 20'h22222); chk("t1_pc1", pc, 1);
        idle_cycle();
        chk("t1_i2", instruction, 20'h33333); chk("t1_pc2", pc, 2);
        idle_cycle();
        chk("t1_i3", instruction, c_nop); chk("t1_pc3", pc, 2); chk("t1_done", done, 1);
        idle_cycle();
        chk("t1_done_low", done, 0); chk("t1_run_low", running, 0);
        idle_cycle();
        chk("t1_done_count", done_seen, 1);

        // Full 32-word store; 33rd word must be refused.
        load_prog(32, 20'h0A000);
        cycle(1'b1, 20'hFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("t2_full_ready", load_ready, 0);
        run_cycles = 0;
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        run_to_idle(40);
        chk("t2_pc_end", pc, 31);
        chk("t2_run_cycles", run_cycles, 32);

        // Five words, three-cycle stall at pc=1.
        load_prog(5, 20'h50000);
        run_cycles = 0;
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        idle_cycle();
        repeat (3) begin
            cycle(1'b0, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
            chk("t3_hold_pc", pc, 1);
        end
        idle_cycle();
        chk("t3_resume_pc", pc, 2);
        run_to_idle(20);
        chk("t3_run_cycles", run_cycles, 8);

        // Jump under stall, then out-of-range jump.
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        idle_cycle();
        cycle(1'b0, 20'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4);
        chk("t4_jump_pc", pc, 4);
        idle_cycle();
        chk("t4_jump_done", done, 1);
        idle_cycle();
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6);
        chk("t4_far_done", done, 1);
        chk("t4_far_nop", instruction, c_nop);
        idle_cycle();

        // clear beats a same-cycle load; start with empty program is ignored.
        cycle(1'b1, 20'h12345, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        chk("t5_start_ignored", running, 0);

        // Asynchronous reset in the middle of a run.
        load_prog(5, 20'h70000);
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        idle_cycle();
        idle_cycle();
        chk("t6_pre_pc", pc, 2);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("t6_instr", instruction, c_nop);
        chk("t6_pc", pc, 0);
        chk("t6_running", running, 0);
        @(posedge clk);
        #1;
        chk("t6_no_done", done, 0);
        rst = 1'b1;
        idle_cycle();

        // Randomized programs with random stalls, jumps and ignored controls.
        for (int p = 0; p < 8; p++) begin
            int n;
            int k;
            n = $urandom_range(1, 32);
            cycle(1'b0, 20'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
            k = 0;
            while (m_wptr < n && k < 200) begin
                cycle(($urandom % 4) != 0, 20'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
                k++;
            end
            cycle($urandom % 2 == 1, 20'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
            k = 0;
            while (m_state != c_m_idle && k < 600) begin
                cycle($urandom % 2 == 1, 20'($urandom), $urandom % 8 == 0, $urandom % 8 == 0,
                      $urandom % 4 == 0, (k < 200) && ($urandom % 8 == 0), 5'($urandom));
                k++;
            end
            chk("rand_budget", k < 600, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
